pipe_hazard_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/hazard_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the three-stage pipeline control path.
// Holds controller state encoding, register address width and NOP encoding.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH      = 2'd1,
    LOAD_STALL = 2'd2,
    MEM_WAIT   = 2'd3
  } ctrl_state_e;

  localparam int REG_ADDR_W = 5;

  // A bubble in IF/EXE is instruction word 0 with every control bit 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [15:0] NOP_CTRL  = 16'h0000;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator between the IF instruction and the load in EXE.
// Purely combinational so a forwarding unit can reuse it.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  exe_is_load,
  input  logic                  exe_reg_we,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic [REG_ADDR_W-1:0] if_rs1,
  input  logic [REG_ADDR_W-1:0] if_rs2,
  input  logic                  if_uses_rs1,
  input  logic                  if_uses_rs2,
  output logic                  load_use
);

  logic hit1;
  logic hit2;

  assign hit1 = if_uses_rs1 && (if_rs1 == exe_rd);
  assign hit2 = if_uses_rs2 && (if_rs2 == exe_rd);

  // x0 is hardwired, so a load targeting it never creates a hazard
  assign load_use = exe_is_load && exe_reg_we
                 && (exe_rd != '0) && (hit1 || hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller driving the PC and IF/EXE register.
// Define PIPE_HAZARD_PERF_EN to add stall/bubble/redirect event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES      = 1,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       exe_branch_taken,
  input  logic       exe_is_load,
  input  logic       exe_reg_we,
  input  logic [4:0] exe_rd,
  input  logic [4:0] if_rs1,
  input  logic [4:0] if_rs2,
  input  logic       if_uses_rs1,
  input  logic       if_uses_rs2,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_stall,
  output logic       pipe_stall,
  output logic       pipe_bubble,
  output logic       pc_redirect,
  output logic [1:0] ctrl_state
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_dec;

  logic load_use;
  logic mem_wait;
  logic pcs;
  logic ps;
  logic pb;
  logic pr;

  hazard_detect u_hazard_detect (
    .exe_is_load (exe_is_load),
    .exe_reg_we  (exe_reg_we),
    .exe_rd      (exe_rd),
    .if_rs1      (if_rs1),
    .if_rs2      (if_rs2),
    .if_uses_rs1 (if_uses_rs1),
    .if_uses_rs2 (if_uses_rs2),
    .load_use    (load_use)
  );

  assign mem_wait = mem_req && !mem_ready;
  assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcs     = 1'b0;
    ps      = 1'b0;
    pb      = 1'b0;
    pr      = 1'b0;
    unique case (state_q)
      RUN: begin
        // Branch squashes everything, including a pending DMEM access
        if (exe_branch_taken) begin
          pr = 1'b1;
          pb = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          end
        end else if (mem_wait) begin
          pcs     = 1'b1;
          ps      = 1'b1;
          state_d = MEM_WAIT;
        end else if (load_use) begin
          pcs = 1'b1;
          pb  = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = LOAD_STALL;
            cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        pb    = 1'b1;
        cnt_d = cnt_dec;
        if (cnt_q <= CNT_W'(1)) state_d = RUN;
      end
      LOAD_STALL: begin
        pcs   = 1'b1;
        pb    = 1'b1;
        cnt_d = cnt_dec;
        if (cnt_q <= CNT_W'(1)) state_d = RUN;
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          pcs = 1'b1;
          ps  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign pc_stall    = rst_n && pcs;
  assign pipe_stall  = rst_n && ps;
  assign pipe_bubble = rst_n && pb;
  assign pc_redirect = rst_n && pr;
  assign ctrl_state  = state_q;

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt    <= '0;
      perf_bubble_cnt   <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      perf_stall_cnt    <= perf_stall_cnt + {31'b0, pc_stall};
      perf_bubble_cnt   <= perf_bubble_cnt + {31'b0, pipe_bubble};
      perf_redirect_cnt <= perf_redirect_cnt + {31'b0, pc_redirect};
    end
  end
`endif

endmodule
